mbox_nxm_ctl: RTL
=================

// Module: mbox_nxm_ctl
// PURPOSE
//  Parametrised successor to the MBOX non-existent-memory (NXM) timeout and error-capture logic.
//  Times each SBUS memory request from NREQ requestors (EBOX, CCA, channels).
//  On timeout, runs a synthetic acknowledge sequence so the MBOX never hangs.
//  Records a per-requestor NXM error and freezes an error address register (ERA) on the first error.
//  Sits in the MBOX between the memory-start logic and the APR error flags.
// PARAMETERS
//  NREQ       4    number of requestors; requestor 0 = EBOX, 1..NREQ-1 = CCA/channels
//  ADR_W      22   physical address width (PMA 14:35)
//  TMO_W      8    timeout counter width
//  TMO_TICKS  255  phase ticks without ACKN before NXM is declared; range 1..2**TMO_W-1
//  NXM_SEQ    5    length of the synthetic sequence in clocks (NXM T2..T6); minimum 3
// PORTS
//  clk           in   1                clock
//  RESET_N       in   1                asynchronous reset, active-low
//  start         in   1                1-clk memory start pulse (MEM START A|B)
//  start_id      in   $clog2(NREQ)     requestor of this start
//  start_adr     in   ADR_W            physical address
//  start_rd      in   1                read request
//  start_wr      in   1                write request; rd and wr together = read-pause-write
//  phase_tick    in   1                A CHANGE COMING; timeout count enable
//  ackn          in   1                memory ACKN pulse
//  err_clr       in   1                clears nxm_err[] and era_valid
//  diag_sel      in   2                diagnostic read select
//  core_busy     out  1                request outstanding or NXM sequence running
//  nxm_ack       out  1                synthetic ACKN, 1 clk
//  nxm_data_val  out  1                synthetic read data valid (all ones), 1 clk
//  nxm_err       out  NREQ             sticky per-requestor NXM error
//  era_valid     out  1                ERA frozen
//  era_adr       out  ADR_W            captured address
//  era_id        out  $clog2(NREQ)     captured requestor
//  era_rd, era_wr out 1 each           captured request type
//  overrun       out  1                sticky: start received while not IDLE
//  diag_data     out  36               EBUS bit order 0:35
// BEHAVIOUR
//  Reset: all outputs, counters and registers are 0; state is IDLE. Reset is asynchronous and may assert mid-sequence.
//  State machine:
//   IDLE -> WAIT on start. Loads id/adr/rd/wr into the request register and clears tcnt.
//   WAIT: phase_tick increments tcnt.
//     ackn -> IDLE. ackn has priority over a same-cycle timeout.
//     tick with tcnt==TMO_TICKS-1 -> NXM; clears scnt.
//   NXM: scnt increments each clk.
//     At scnt==NXM_SEQ-2: nxm_ack=1, and nxm_data_val=start_rd latched.
//     At scnt==NXM_SEQ-1: -> IDLE and set nxm_err[id].
//     ackn during NXM is ignored.
//  core_busy is registered: 1 the clk after start, 0 the clk after returning to IDLE.
//  start while not IDLE: the start is dropped, overrun is set, and the state is unchanged.
//  start in the same cycle the FSM enters IDLE is also dropped and sets overrun.
//  ERA: on entry to NXM with era_valid=0, capture the request register and set era_valid.
//   Later errors do not overwrite the ERA.
//  err_clr clears nxm_err and era_valid.
//   A same-cycle nxm_err set wins for that bit; a same-cycle capture wins for era_valid.
//   overrun is cleared only by reset.
//  tcnt never wraps; it holds at TMO_TICKS-1 until the transition.
//  diag_data (other bits 0):
//   sel 0: adr right-justified in 14:35
//   sel 1: era_id in 0:3, rd 4, wr 5, era_valid 6, overrun 7
//   sel 2: nxm_err right-justified in 36-NREQ..35
//   sel 3: state in 0:1, tcnt right-justified in 28:35
// CONFIGURATION
//  MBOX_NXM_ERRCNT_EN defined: adds a 16-bit saturating count of NXM events.
//   Cleared by err_clr; a same-cycle increment wins.
//   Readable on diag_sel 3, bits 2:17.
//  Undefined: no counter, and those bits read 0.
// STRUCTURE
//  Package mbox_nxm_pkg: typedef enum {IDLE, WAIT, NXM} nxm_state_t; typedef for the request record
//   {adr, id, rd, wr}; DIAG_* field position constants.
//  One sub-module, mbox_nxm_timer: tcnt with clear/enable and a terminal-count output.
//  The parent holds the FSM, scnt, ERA, error flags and diag mux.
// TESTING (NREQ=4, TMO_TICKS=4, NXM_SEQ=5)
//  start id=2 rd adr=0x1234, ackn after 3 ticks -> no nxm_ack, nxm_err=0, core_busy drops 1 clk after ackn
//  start id=1 rd, 4 ticks and no ackn -> NXM; nxm_ack+nxm_data_val 3 clks later; nxm_err=4'b0010; era_adr=0x1234, era_id=1
//  second NXM from id=3 wr -> nxm_err=4'b1010; ERA still holds id=1; err_clr -> nxm_err=0, era_valid=0
//  ackn and the 4th tick in the same cycle -> IDLE, no NXM; start during NXM -> overrun=1, sequence unaffected
//  RESET_N low mid-NXM -> all outputs 0 immediately; next start times normally
//  MBOX_NXM_ERRCNT_EN: 3 NXMs -> diag_sel 3 bits 2:17 = 3; err_clr with a 4th NXM completing in the same cycle -> 1

Source files
------------

// File: rtl/mbox_nxm_pkg.sv
// Shared types and diagnostic field positions for the MBOX NXM timeout/error-capture block.
// Diagnostic positions are vector indices; EBUS bit k corresponds to index 35-k.
package mbox_nxm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        NXM  = 2'd2
    } nxm_state_t;

    // Request record sized for the widest diagnostic fields (36-bit address, 4-bit id)
    localparam int unsigned REQ_ADR_MAX_W = 36;
    localparam int unsigned REQ_ID_MAX_W  = 4;

    typedef struct packed {
        logic [REQ_ADR_MAX_W-1:0] adr;
        logic [REQ_ID_MAX_W-1:0]  id;
        logic                     rd;
        logic                     wr;
    } nxm_req_t;

    localparam int unsigned DIAG_W          = 36;
    localparam int unsigned DIAG_ERA_ID_LSB = 32;
    localparam int unsigned DIAG_ERA_RD     = 31;
    localparam int unsigned DIAG_ERA_WR     = 30;
    localparam int unsigned DIAG_ERA_VALID  = 29;
    localparam int unsigned DIAG_OVERRUN    = 28;
    localparam int unsigned DIAG_STATE_LSB  = 34;
    localparam int unsigned DIAG_ERRCNT_LSB = 18;
    localparam int unsigned DIAG_ERRCNT_W   = 16;

endpackage

// File: rtl/mbox_nxm_timer.sv
// Phase-tick timeout counter: clears on request start, counts enabled ticks and
// holds at the terminal value TMO_TICKS-1 instead of wrapping.
module mbox_nxm_timer
    import mbox_nxm_pkg::*;
#(
    parameter int unsigned TMO_W     = 8,
    parameter int unsigned TMO_TICKS = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [TMO_W-1:0] tcnt,
    output logic             tc
);

    logic [TMO_W-1:0] tcnt_r;
    logic             tc_s;

    assign tc_s = (tcnt_r == TMO_W'(TMO_TICKS - 1));

    // Tick counter with clear priority and saturation at terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_r <= {TMO_W{1'b0}};
        end else if (clr) begin
            tcnt_r <= {TMO_W{1'b0}};
        end else if (en && !tc_s) begin
            tcnt_r <= tcnt_r + TMO_W'(1);
        end else begin
            tcnt_r <= tcnt_r;
        end
    end

    assign tcnt = tcnt_r;
    assign tc   = tc_s;

endmodule

// File: rtl/mbox_nxm_ctl.sv
// MBOX NXM controller: times SBUS requests, runs a synthetic ACKN sequence on timeout and
// captures the first error in the ERA. Optional NXM event counter under MBOX_NXM_ERRCNT_EN.
module mbox_nxm_ctl
    import mbox_nxm_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned ADR_W     = 22,
    parameter int unsigned TMO_W     = 8,
    parameter int unsigned TMO_TICKS = 255,
    parameter int unsigned NXM_SEQ   = 5
) (
    input  logic                    clk,
    input  logic                    RESET_N,
    input  logic                    start,
    input  logic [$clog2(NREQ)-1:0] start_id,
    input  logic [ADR_W-1:0]        start_adr,
    input  logic                    start_rd,
    input  logic                    start_wr,
    input  logic                    phase_tick,
    input  logic                    ackn,
    input  logic                    err_clr,
    input  logic [1:0]              diag_sel,
    output logic                    core_busy,
    output logic                    nxm_ack,
    output logic                    nxm_data_val,
    output logic [NREQ-1:0]         nxm_err,
    output logic                    era_valid,
    output logic [ADR_W-1:0]        era_adr,
    output logic [$clog2(NREQ)-1:0] era_id,
    output logic                    era_rd,
    output logic                    era_wr,
    output logic                    overrun,
    output logic [35:0]             diag_data
);

    localparam int unsigned ID_W   = $clog2(NREQ);
    localparam int unsigned SCNT_W = $clog2(NXM_SEQ);

    nxm_state_t         state_r;
    nxm_state_t         state_s;
    nxm_req_t           req_r;
    nxm_req_t           era_r;
    logic               era_valid_r;
    logic [SCNT_W-1:0]  scnt_r;
    logic [NREQ-1:0]    nxm_err_r;
    logic [NREQ-1:0]    err_set_s;
    logic               overrun_r;
    logic               core_busy_r;
    logic               nxm_ack_r;
    logic               nxm_data_val_r;
    logic [DIAG_W-1:0]  diag_r;
    logic [DIAG_W-1:0]  diag_s;
    logic [TMO_W-1:0]   tcnt_s;
    logic               tc_s;
    logic               accept_s;
    logic               tmr_en_s;
    logic               timeout_s;
    logic               seq_ack_s;
    logic               seq_end_s;
    logic               capture_s;

    mbox_nxm_timer #(
        .TMO_W     (TMO_W),
        .TMO_TICKS (TMO_TICKS)
    ) u_timer (
        .clk   (clk),
        .rst_n (RESET_N),
        .clr   (accept_s),
        .en    (tmr_en_s),
        .tcnt  (tcnt_s),
        .tc    (tc_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state; ackn beats a same-cycle timeout, and is ignored once in NXM
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (ackn) begin
                    state_s = IDLE;
                end else if (phase_tick && tc_s) begin
                    state_s = NXM;
                end else begin
                    state_s = WAIT;
                end
            end
            NXM: begin
                if (scnt_r == SCNT_W'(NXM_SEQ - 1)) begin
                    state_s = IDLE;
                end else begin
                    state_s = NXM;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM decoded actions; ack is decoded one step early so the registered pulse lands on NXM_SEQ-2
    always_comb begin
        accept_s  = 1'b0;
        tmr_en_s  = 1'b0;
        timeout_s = 1'b0;
        seq_ack_s = 1'b0;
        seq_end_s = 1'b0;
        case (state_r)
            IDLE: begin
                accept_s = start;
            end
            WAIT: begin
                tmr_en_s  = phase_tick;
                timeout_s = phase_tick && tc_s && !ackn;
            end
            NXM: begin
                seq_ack_s = (scnt_r == SCNT_W'(NXM_SEQ - 3));
                seq_end_s = (scnt_r == SCNT_W'(NXM_SEQ - 1));
            end
            default: begin
                accept_s = 1'b0;
            end
        endcase
        capture_s = timeout_s && !era_valid_r;
        if (seq_end_s) begin
            err_set_s = NREQ'(1'b1) << req_r.id;
        end else begin
            err_set_s = {NREQ{1'b0}};
        end
    end

    // Request register loaded on an accepted start
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            req_r <= '0;
        end else if (accept_s) begin
            req_r <= '{adr: REQ_ADR_MAX_W'(start_adr), id: REQ_ID_MAX_W'(start_id),
                       rd: start_rd, wr: start_wr};
        end else begin
            req_r <= req_r;
        end
    end

    // Synthetic sequence step counter
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            scnt_r <= {SCNT_W{1'b0}};
        end else if (timeout_s) begin
            scnt_r <= {SCNT_W{1'b0}};
        end else if (state_r == NXM) begin
            scnt_r <= scnt_r + SCNT_W'(1);
        end else begin
            scnt_r <= scnt_r;
        end
    end

    // Registered handshake outputs
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            core_busy_r    <= 1'b0;
            nxm_ack_r      <= 1'b0;
            nxm_data_val_r <= 1'b0;
        end else begin
            core_busy_r    <= (state_s != IDLE);
            nxm_ack_r      <= seq_ack_s;
            nxm_data_val_r <= seq_ack_s && req_r.rd;
        end
    end

    // Sticky error flags: a same-cycle set survives err_clr; overrun clears only on reset
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            nxm_err_r <= {NREQ{1'b0}};
            overrun_r <= 1'b0;
        end else begin
            nxm_err_r <= (err_clr ? {NREQ{1'b0}} : nxm_err_r) | err_set_s;
            overrun_r <= overrun_r | (start && (state_r != IDLE));
        end
    end

    // ERA freezes on the first NXM entry; capture beats a same-cycle err_clr
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            era_r       <= '0;
            era_valid_r <= 1'b0;
        end else if (capture_s) begin
            era_r       <= req_r;
            era_valid_r <= 1'b1;
        end else if (err_clr) begin
            era_r       <= era_r;
            era_valid_r <= 1'b0;
        end else begin
            era_r       <= era_r;
            era_valid_r <= era_valid_r;
        end
    end

`ifdef MBOX_NXM_ERRCNT_EN
    logic [DIAG_ERRCNT_W-1:0] errcnt_r;

    // Saturating NXM completion count; a completing NXM beats a same-cycle clear
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            errcnt_r <= {DIAG_ERRCNT_W{1'b0}};
        end else if (err_clr) begin
            errcnt_r <= DIAG_ERRCNT_W'(seq_end_s);
        end else if (seq_end_s && (errcnt_r != {DIAG_ERRCNT_W{1'b1}})) begin
            errcnt_r <= errcnt_r + DIAG_ERRCNT_W'(1);
        end else begin
            errcnt_r <= errcnt_r;
        end
    end
`endif

    // Diagnostic read mux in EBUS order
    always_comb begin
        diag_s = {DIAG_W{1'b0}};
        case (diag_sel)
            2'd0: begin
                diag_s = era_r.adr;
            end
            2'd1: begin
                diag_s[DIAG_ERA_ID_LSB +: REQ_ID_MAX_W] = era_r.id;
                diag_s[DIAG_ERA_RD]                     = era_r.rd;
                diag_s[DIAG_ERA_WR]                     = era_r.wr;
                diag_s[DIAG_ERA_VALID]                  = era_valid_r;
                diag_s[DIAG_OVERRUN]                    = overrun_r;
            end
            2'd2: begin
                diag_s[NREQ-1:0] = nxm_err_r;
            end
            2'd3: begin
                diag_s[DIAG_STATE_LSB +: 2] = state_r;
                diag_s[TMO_W-1:0]           = tcnt_s;
`ifdef MBOX_NXM_ERRCNT_EN
                diag_s[DIAG_ERRCNT_LSB +: DIAG_ERRCNT_W] = errcnt_r;
`else
                diag_s[DIAG_ERRCNT_LSB +: DIAG_ERRCNT_W] = {DIAG_ERRCNT_W{1'b0}};
`endif
            end
            default: begin
                diag_s = {DIAG_W{1'b0}};
            end
        endcase
    end

    // Registered diagnostic output
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            diag_r <= {DIAG_W{1'b0}};
        end else begin
            diag_r <= diag_s;
        end
    end

    assign core_busy    = core_busy_r;
    assign nxm_ack      = nxm_ack_r;
    assign nxm_data_val = nxm_data_val_r;
    assign nxm_err      = nxm_err_r;
    assign era_valid    = era_valid_r;
    assign era_adr      = era_r.adr[ADR_W-1:0];
    assign era_id       = era_r.id[ID_W-1:0];
    assign era_rd       = era_r.rd;
    assign era_wr       = era_r.wr;
    assign overrun      = overrun_r;
    assign diag_data    = diag_r;

endmodule
